// File: rtl/fetch_pkg.sv
// Shared types and default widths for the tick-paced instruction fetch controller.
package fetch_pkg;

  localparam int ADDR_W = 5;
  localparam int DATA_W = 9;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    RUN   = 3'd3,
    NEXT  = 3'd4,
    HALT  = 3'd5
  } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector; the flop resets high so an input already high at reset release is not an edge.
module edge_detect (
  input  logic Clock,
  input  logic Reset,
  input  logic D,
  output logic Rise
);

  logic d_q;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) d_q <= 1'b1;
    else       d_q <= D;
  end

  assign Rise = D & ~d_q;

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Tick-paced fetch controller: each accepted tick edge reads one ROM word, strobes Run
// to the processor and waits for Done before advancing the ROM address.
module instr_fetch_ctrl #(
  parameter int ADDR_W    = fetch_pkg::ADDR_W,
  parameter int DATA_W    = fetch_pkg::DATA_W,
  parameter int LAST_ADDR = 31,
  parameter bit WRAP      = 1'b1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Tick,
  input  logic              Enable,
  input  logic              Done,
  input  logic [DATA_W-1:0] ROM_data,
  output logic [ADDR_W-1:0] ROM_addr,
  output logic [DATA_W-1:0] IR_out,
  output logic              Run,
  output logic              Busy,
  output logic              Overrun,
  output logic              Halted,
  output logic [2:0]        Dbg_state
);

  import fetch_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = LAST_ADDR[ADDR_W-1:0];

  state_t state;
  logic   tick_edge;
  logic   first_run;
  logic   in_flight;

  edge_detect u_tick_edge (
    .Clock (Clock),
    .Reset (Reset),
    .D     (Tick),
    .Rise  (tick_edge)
  );

  assign in_flight = (state == FETCH) || (state == LOAD) ||
                     (state == RUN)   || (state == NEXT);
  assign Dbg_state = state;

  // Run/Done handshake: Run is held high for the whole RUN state; Done is only
  // accepted from the second RUN cycle on, so a Done left high from the previous
  // instruction cannot complete the new one before the processor has seen it.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ROM_addr  <= '0;
      IR_out    <= '0;
      Run       <= 1'b0;
      Busy      <= 1'b0;
      Overrun   <= 1'b0;
      Halted    <= 1'b0;
      first_run <= 1'b0;
    end else begin
      Overrun <= tick_edge & in_flight;
      case (state)
        IDLE: begin
          if (tick_edge && Enable) begin
            state <= FETCH;
            Busy  <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          IR_out    <= ROM_data;
          state     <= RUN;
          Run       <= 1'b1;
          first_run <= 1'b1;
        end
        RUN: begin
          first_run <= 1'b0;
          if (!first_run && Done) begin
            state <= NEXT;
            Run   <= 1'b0;
          end
        end
        NEXT: begin
          Busy <= 1'b0;
          if (ROM_addr == LAST) begin
            if (WRAP) begin
              ROM_addr <= '0;
              state    <= IDLE;
            end else begin
              state  <= HALT;
              Halted <= 1'b1;
            end
          end else begin
            ROM_addr <= ROM_addr + ADDR_W'(1);
            state    <= IDLE;
          end
        end
        HALT: state <= HALT;
        default: begin
          state <= IDLE;
          Run   <= 1'b0;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed bench: a halting (WRAP=0) and a wrapping (WRAP=1) controller, both with
// LAST_ADDR=3, share stimulus; each has its own synchronous ROM model.
module tb_instr_fetch_ctrl;

  logic       Clock, Reset, Tick, Enable, Done;
  logic [4:0] addr_h, addr_w;
  logic [8:0] data_h, data_w, ir_h, ir_w;
  logic       run_h, run_w, busy_h, busy_w, ovr_h, ovr_w, halt_h, halt_w;
  logic [2:0] st_h, st_w;
  logic [8:0] rom [32];

  int tests = 0;
  int failed = 0;
  int run_cnt_h = 0, run_cnt_w = 0, ovr_cnt_h = 0, ovr_cnt_w = 0;

  instr_fetch_ctrl #(.ADDR_W(5), .DATA_W(9), .LAST_ADDR(3), .WRAP(1'b0)) dut_h (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Enable(Enable), .Done(Done),
    .ROM_data(data_h), .ROM_addr(addr_h), .IR_out(ir_h), .Run(run_h),
    .Busy(busy_h), .Overrun(ovr_h), .Halted(halt_h), .Dbg_state(st_h)
  );

  instr_fetch_ctrl #(.ADDR_W(5), .DATA_W(9), .LAST_ADDR(3), .WRAP(1'b1)) dut_w (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Enable(Enable), .Done(Done),
    .ROM_data(data_w), .ROM_addr(addr_w), .IR_out(ir_w), .Run(run_w),
    .Busy(busy_w), .Overrun(ovr_w), .Halted(halt_w), .Dbg_state(st_w)
  );

  // clock / reset block
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  always @(posedge Clock) begin
    data_h <= rom[addr_h];
    data_w <= rom[addr_w];
  end

  always @(posedge run_h) run_cnt_h++;
  always @(posedge run_w) run_cnt_w++;
  always @(posedge ovr_h) ovr_cnt_h++;
  always @(posedge ovr_w) ovr_cnt_w++;

  initial begin
    #100000;
    $display("FAIL watchdog: no finish after 100000 time units");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // One full fetch at minimum spacing; Done is sampled 4+extra edges after the tick edge.
  task automatic step(input logic [8:0] exp_ir_h, input logic [8:0] exp_ir_w,
                      input logic exp_run_h, input int extra);
    Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    repeat (2) @(negedge Clock);
    check("step_run_w", run_w, 1);
    check("step_ir_w", ir_w, exp_ir_w);
    check("step_run_h", run_h, exp_run_h);
    check("step_ir_h", ir_h, exp_ir_h);
    repeat (1 + extra) @(negedge Clock);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 9'(i * 7);
    rom[0] = 9'h1A5;
    rom[1] = 9'h0C3;
    rom[2] = 9'h155;
    rom[3] = 9'h02A;

    Reset = 1'b1; Tick = 1'b1; Enable = 1'b0; Done = 1'b0;
    repeat (3) @(negedge Clock);
    check("rst_addr", {addr_h, addr_w}, 0);
    check("rst_ir", {ir_h, ir_w}, 0);
    check("rst_flags", {run_h, busy_h, ovr_h, halt_h, run_w, busy_w, ovr_w, halt_w}, 0);

    // Tick already high at reset release must not start a fetch
    Reset = 1'b0; Enable = 1'b1;
    repeat (3) @(negedge Clock);
    check("tick_at_release", busy_h, 0);
    Tick = 1'b0;
    @(negedge Clock);

    // Tick with Enable low is dropped silently
    Enable = 1'b0; Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    repeat (3) @(negedge Clock);
    check("disabled_busy", busy_h, 0);
    check("disabled_ovr", ovr_cnt_h, 0);
    Enable = 1'b1;

    // Single step with cycle-exact checks
    Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    check("ss_fetch_busy", busy_h, 1);
    check("ss_fetch_run", run_h, 0);
    @(negedge Clock);
    check("ss_load_run", run_h, 0);
    for (int c = 3; c <= 6; c++) begin
      @(negedge Clock);
      check("ss_run", run_h, 1);
      check("ss_ir", ir_h, 9'h1A5);
    end
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    check("ss_run_low", run_h, 0);
    check("ss_addr_hold", addr_h, 0);
    @(negedge Clock);
    check("ss_addr_next", addr_h, 1);
    check("ss_idle_busy", busy_h, 0);

    // Level tick with Done held high: exactly one fetch
    Done = 1'b1; Tick = 1'b1;
    repeat (20) @(negedge Clock);
    Tick = 1'b0; Done = 1'b0;
    @(negedge Clock);
    check("level_addr", addr_h, 2);
    check("level_runs", run_cnt_h, 2);
    check("level_ir", ir_h, 9'h0C3);

    // Second tick edge during RUN raises a one-cycle Overrun and is dropped
    Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    repeat (2) @(negedge Clock);
    check("ovr_ir", ir_h, 9'h155);
    Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    check("ovr_pulse", ovr_h, 1);
    @(negedge Clock);
    check("ovr_one_cycle", ovr_h, 0);
    Done = 1'b1;
    @(negedge Clock);
    Done = 1'b0;
    repeat (5) @(negedge Clock);
    check("ovr_addr", addr_h, 3);
    check("ovr_count", ovr_cnt_h, 1);
    check("ovr_runs", run_cnt_h, 3);
    check("ovr_busy", busy_h, 0);

    // Fourth step at LAST_ADDR: halting copy stops, wrapping copy returns to 0
    step(9'h02A, 9'h02A, 1'b1, 0);
    check("end_halted_h", halt_h, 1);
    check("end_addr_h", addr_h, 3);
    check("end_busy_h", busy_h, 0);
    check("end_halted_w", halt_w, 0);
    check("end_addr_w", addr_w, 0);

    // Fifth step: wrap copy fetches address 0, halted copy ignores the tick
    step(9'h02A, 9'h1A5, 1'b0, 0);
    check("halt_runs", run_cnt_h, 4);
    check("halt_ovr", ovr_cnt_h, 1);
    check("halt_addr", addr_h, 3);
    check("halt_still", halt_h, 1);
    check("wrap_addr", addr_w, 1);
    check("wrap_runs", run_cnt_w, 5);

    // Reset in the middle of RUN with Done never asserted
    Tick = 1'b1;
    @(negedge Clock);
    Tick = 1'b0;
    repeat (2) @(negedge Clock);
    check("mid_run_w", run_w, 1);
    check("mid_ir_w", ir_w, 9'h0C3);
    #2 Reset = 1'b1;
    #1;
    check("mid_rst_run", run_w, 0);
    check("mid_rst_busy", busy_w, 0);
    check("mid_rst_addr", {addr_h, addr_w}, 0);
    check("mid_rst_ir", {ir_h, ir_w}, 0);
    check("mid_rst_halt", halt_h, 0);
    @(negedge Clock);
    Reset = 1'b0;
    @(negedge Clock);
    step(9'h1A5, 9'h1A5, 1'b1, 1);
    check("post_rst_addr_h", addr_h, 1);
    check("post_rst_addr_w", addr_w, 1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
